weight_fetch: RTL

WEIGHT_FETCH -- requirements
Module: weight_fetch

---
 rtl/weight_fetch_if.sv | 31 +++
 rtl/weight_fetch.sv | 139 +++++++++++++
 2 files changed

// File: rtl/weight_fetch_if.sv
// Command, external read and weight-memory write signals of the weight fetch engine.
// slave is the fetch engine's view; master is the issuing/observing side.
interface weight_fetch_if #(
  parameter int DATA_BUS_WIDTH = 128,
  parameter int SRC_ADDR_WIDTH = 16,
  parameter int DST_ADDR_WIDTH = 8
);
  logic                      weight_fetch_enable;
  logic [SRC_ADDR_WIDTH-1:0] src_addr;
  logic [DST_ADDR_WIDTH-1:0] dst_addr;
  logic [7:0]                fetch_counter;
  logic [DATA_BUS_WIDTH-1:0] i_data;
  logic [SRC_ADDR_WIDTH-1:0] fetch_addr;
  logic                      read_data;
  logic [DST_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_BUS_WIDTH-1:0] wr_data;
  logic                      wr_en;
  logic                      fetch_done;
  logic                      busy;
  logic                      cmd_overrun;

  modport slave (
    input  weight_fetch_enable, src_addr, dst_addr, fetch_counter, i_data,
    output fetch_addr, read_data, wr_addr, wr_data, wr_en, fetch_done, busy, cmd_overrun
  );

  modport master (
    output weight_fetch_enable, src_addr, dst_addr, fetch_counter, i_data,
    input  fetch_addr, read_data, wr_addr, wr_data, wr_en, fetch_done, busy, cmd_overrun
  );
endinterface

// File: rtl/weight_fetch.sv
// Burst copy of N words from the external bus into weight memory, one read per cycle,
// each word written back one cycle after its read strobe. All outputs registered.
//
// state | meaning
// IDLE  | waiting for weight_fetch_enable
// READ  | issuing reads src+0 .. src+N-1
// DRAIN | final write in flight, no read
// DONE  | fetch_done pulse, back to IDLE
module weight_fetch #(
  parameter int DATA_BUS_WIDTH = 128,
  parameter int SRC_ADDR_WIDTH = 16,
  parameter int DST_ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  weight_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                    state, state_nxt;
  logic [SRC_ADDR_WIDTH-1:0] src_q, src_nxt;
  logic [DST_ADDR_WIDTH-1:0] dst_q, dst_nxt;
  logic [7:0]                n_q, n_nxt;
  logic [7:0]                k_q, k_nxt;

  logic [SRC_ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_nxt;
  logic                      read_q, read_nxt;
  logic [DST_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_nxt;
  logic [DATA_BUS_WIDTH-1:0] wr_data_q, wr_data_nxt;
  logic                      wr_en_q, wr_en_nxt;
  logic                      done_q, done_nxt;
  logic                      busy_q, busy_nxt;
  logic                      overrun_q, overrun_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      n_q          <= '0;
      k_q          <= '0;
      fetch_addr_q <= '0;
      read_q       <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      src_q        <= src_nxt;
      dst_q        <= dst_nxt;
      n_q          <= n_nxt;
      k_q          <= k_nxt;
      fetch_addr_q <= fetch_addr_nxt;
      read_q       <= read_nxt;
      wr_addr_q    <= wr_addr_nxt;
      wr_data_q    <= wr_data_nxt;
      wr_en_q      <= wr_en_nxt;
      done_q       <= done_nxt;
      busy_q       <= busy_nxt;
      overrun_q    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    src_nxt        = src_q;
    dst_nxt        = dst_q;
    n_nxt          = n_q;
    k_nxt          = k_q;
    fetch_addr_nxt = fetch_addr_q;
    read_nxt       = 1'b0;
    wr_addr_nxt    = wr_addr_q;
    wr_data_nxt    = wr_data_q;
    wr_en_nxt      = 1'b0;
    done_nxt       = 1'b0;
    overrun_nxt    = overrun_q;

    // The word read in the current cycle is captured at this edge; k already counts it.
    if (read_q) begin
      wr_en_nxt   = 1'b1;
      wr_data_nxt = bus.i_data;
      wr_addr_nxt = dst_q + DST_ADDR_WIDTH'(k_q - 8'd1);
    end

    case (state)
      IDLE: begin
        if (bus.weight_fetch_enable) begin
          src_nxt = bus.src_addr;
          dst_nxt = bus.dst_addr;
          n_nxt   = bus.fetch_counter;
          k_nxt   = '0;
          if (bus.fetch_counter != 8'd0) begin
            state_nxt      = READ;
            read_nxt       = 1'b1;
            fetch_addr_nxt = bus.src_addr;
            k_nxt          = 8'd1;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      READ: begin
        if (k_q == n_q) begin
          state_nxt = DRAIN;
        end else begin
          read_nxt       = 1'b1;
          fetch_addr_nxt = src_q + SRC_ADDR_WIDTH'(k_q);
          k_nxt          = k_q + 8'd1;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state != IDLE && bus.weight_fetch_enable) overrun_nxt = 1'b1;
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.fetch_addr  = fetch_addr_q;
  assign bus.read_data   = read_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.fetch_done  = done_q;
  assign bus.busy        = busy_q;
  assign bus.cmd_overrun = overrun_q;
endmodule
